// File: rtl/hubris_pkg.sv
// Shared constants and address helpers for the Hubris RV32 system.
package hubris_pkg;

  localparam int XLEN           = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 1048576;

  // Byte address to word index, dropping the byte offset and wrapping
  // modulo a memory of 2**aw words.
  function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] addr,
                                                 input int unsigned     aw);
    logic [XLEN-1:0] mask;
    mask = (XLEN'(1) << aw) - XLEN'(1);
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/new_unified_memory_ram_port.sv
// One port of the unified RAM: write-lane gating and the read-first
// output register. The storage array itself lives in the parent.
module ram_port
  import hubris_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [BYTES_PER_WORD-1:0] we,
  input  logic [XLEN-1:0]           rd_word,
  output logic [BYTES_PER_WORD-1:0] wr_lane,
  output logic [XLEN-1:0]           dout
);

  // A lane is written only when the port is enabled and reset is released.
  always_comb begin
    wr_lane = '0;
    if (en && reset) begin
      wr_lane = we;
    end
  end

  // Capture the pre-edge word whenever the port is enabled; clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= '0;
    end else if (en) begin
      dout <= rd_word;
    end
  end

endmodule

// File: rtl/new_unified_memory.sv
// Unified instruction/data RAM: true dual-port, byte-writable, synchronous
// read. Port A is load/store traffic, port B is instruction fetch.
module new_unified_memory
  import hubris_pkg::*;
#(
  parameter int MEMORY_WIDTH_IN_BYTE = 4,
  parameter int MEMORY_DEPTH_IN_WORD = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_a,
  input  logic [BYTES_PER_WORD-1:0] we_a,
  input  logic [XLEN-1:0]           addr_a,
  input  logic [XLEN-1:0]           din_a,
  output logic [XLEN-1:0]           dout_a,
  input  logic                      en_b,
  input  logic [BYTES_PER_WORD-1:0] we_b,
  input  logic [XLEN-1:0]           addr_b,
  input  logic [XLEN-1:0]           din_b,
  output logic [XLEN-1:0]           dout_b
);

  localparam int AW = $clog2(MEMORY_DEPTH_IN_WORD);

  if (MEMORY_WIDTH_IN_BYTE != BYTES_PER_WORD) begin : g_bad_width
    $error("new_unified_memory supports only 4-byte words");
  end
  if ((MEMORY_DEPTH_IN_WORD < 2) || ((1 << AW) != MEMORY_DEPTH_IN_WORD)) begin : g_bad_depth
    $error("MEMORY_DEPTH_IN_WORD must be a power of two and at least 2");
  end

  // Kept as plain reg so simulation preloads and dumps can reach it by name.
  reg [XLEN-1:0] mem [0:MEMORY_DEPTH_IN_WORD-1];

  logic [AW-1:0]             idx_a;
  logic [AW-1:0]             idx_b;
  logic [XLEN-1:0]           rd_a;
  logic [XLEN-1:0]           rd_b;
  logic [BYTES_PER_WORD-1:0] wr_a;
  logic [BYTES_PER_WORD-1:0] wr_b;

  assign idx_a = AW'(word_index(addr_a, AW));
  assign idx_b = AW'(word_index(addr_b, AW));
  assign rd_a  = mem[idx_a];
  assign rd_b  = mem[idx_b];

  ram_port u_port_a (
    .clk     (clk),
    .reset   (reset),
    .en      (en_a),
    .we      (we_a),
    .rd_word (rd_a),
    .wr_lane (wr_a),
    .dout    (dout_a)
  );

  ram_port u_port_b (
    .clk     (clk),
    .reset   (reset),
    .en      (en_b),
    .we      (we_b),
    .rd_word (rd_b),
    .wr_lane (wr_b),
    .dout    (dout_b)
  );

  // Byte-lane writes; port A's lanes are applied after port B's so A wins
  // a same-word, same-lane collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (wr_b[i]) begin
        mem[idx_b][i*8 +: 8] <= din_b[i*8 +: 8];
      end
    end
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (wr_a[i]) begin
        mem[idx_a][i*8 +: 8] <= din_a[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_new_unified_memory.sv
// Self-checking bench for new_unified_memory against a word-level model.
module tb_new_unified_memory;

  localparam int DEPTH = 1048576;

  logic        clk;
  logic        reset;
  logic        en_a;
  logic [3:0]  we_a;
  logic [31:0] addr_a;
  logic [31:0] din_a;
  logic [31:0] dout_a;
  logic        en_b;
  logic [3:0]  we_b;
  logic [31:0] addr_b;
  logic [31:0] din_b;
  logic [31:0] dout_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [int];
  logic [31:0] exp_a;
  logic [31:0] exp_b;

  new_unified_memory #(
    .MEMORY_WIDTH_IN_BYTE (4),
    .MEMORY_DEPTH_IN_WORD (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en_a   (en_a),
    .we_a   (we_a),
    .addr_a (addr_a),
    .din_a  (din_a),
    .dout_a (dout_a),
    .en_b   (en_b),
    .we_b   (we_b),
    .addr_b (addr_b),
    .din_b  (din_b),
    .dout_b (dout_b)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] get_word(input int w);
    if (model_mem.exists(w)) return model_mem[w];
    return 'x;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[i*8 +: 8] = din[i*8 +: 8];
    end
    return r;
  endfunction

  task automatic preload(input int w, input logic [31:0] v);
    dut.mem[w]  = v;
    model_mem[w] = v;
  endtask

  // Drive one cycle on both ports (called just after a falling edge), step
  // the model at the rising edge, then check both outputs.
  task automatic apply_stimulus(input logic ea, input logic [3:0] wa,
                                input logic [31:0] aa, input logic [31:0] da,
                                input logic eb, input logic [3:0] wb,
                                input logic [31:0] ab, input logic [31:0] db,
                                input string tag);
    int ia;
    int ib;
    logic [31:0] old_a;
    logic [31:0] old_b;
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    @(posedge clk);
    if (reset) begin
      ia = widx(aa);
      ib = widx(ab);
      old_a = get_word(ia);
      old_b = get_word(ib);
      if (ea) exp_a = old_a;
      if (eb) exp_b = old_b;
      if (eb && wb != 4'b0) model_mem[ib] = merge(get_word(ib), db, wb);
      if (ea && wa != 4'b0) model_mem[ia] = merge(get_word(ia), da, wa);
    end
    #1;
    check_output({tag, "/dout_a"}, dout_a, exp_a);
    check_output({tag, "/dout_b"}, dout_b, exp_b);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr(input int w);
    return ($urandom() << 22) | (32'(w) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    clk = 0;
    reset = 1;
    en_a = 0; we_a = 0; addr_a = 0; din_a = 0;
    en_b = 0; we_b = 0; addr_b = 0; din_b = 0;
    exp_a = 0;
    exp_b = 0;

    for (int w = 0; w < 512; w++) preload(w, $urandom());
    preload(0, 32'h0000_0013);
    preload(1, 32'hAABB_CCDD);
    preload(2, 32'h0000_0000);
    preload(4, 32'hFFFF_FFFF);

    // Reset clears outputs asynchronously and blocks writes.
    @(negedge clk);
    @(negedge clk);
    #2 reset = 0;
    exp_a = 0;
    exp_b = 0;
    #1;
    check_output("reset_async_a", dout_a, 32'h0);
    check_output("reset_async_b", dout_b, 32'h0);
    @(negedge clk);
    apply_stimulus(1, 4'hF, 32'h0, 32'hBAD0_BAD0, 1, 4'h0, 32'h0, 32'h0, "rst_hold");
    reset = 1;
    apply_stimulus(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, "rel_idle");
    apply_stimulus(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0, "boot_fetch");
    check_output("boot_word", dout_b, 32'h0000_0013);

    // Byte-lane write and intra-word address aliasing.
    apply_stimulus(1, 4'b0101, 32'h4, 32'h1122_3344, 0, 4'h0, 32'h0, 32'h0, "lane_wr");
    apply_stimulus(1, 4'h0, 32'h4, 32'h0, 1, 4'h0, 32'h5, 32'h0, "lane_rd");
    check_output("lane_word", dout_a, 32'hAA22_CC44);
    apply_stimulus(1, 4'h0, 32'h6, 32'h0, 1, 4'h0, 32'h7, 32'h0, "lane_alias");
    check_output("lane_alias7", dout_b, 32'hAA22_CC44);

    // Read-first on the same port.
    apply_stimulus(1, 4'hF, 32'h8, 32'hDEAD_BEEF, 0, 4'h0, 32'h0, 32'h0, "rf_wr");
    check_output("rf_old", dout_a, 32'h0);
    apply_stimulus(1, 4'h0, 32'h8, 32'h0, 0, 4'h0, 32'h0, 32'h0, "rf_rd");
    check_output("rf_new", dout_a, 32'hDEAD_BEEF);

    // Cross-port collision: A wins shared lanes.
    apply_stimulus(1, 4'b0011, 32'h10, 32'h0102_0304, 1, 4'b0110, 32'h10, 32'hA0B0_C0D0, "coll_wr");
    apply_stimulus(1, 4'h0, 32'h10, 32'h0, 1, 4'h0, 32'h10, 32'h0, "coll_rd");
    check_output("coll_word", dout_a, 32'hFFB0_0304);

    // Wrap modulo depth, then enable gating.
    apply_stimulus(1, 4'hF, 32'h0040_0000, 32'h5A5A_5A5A, 0, 4'h0, 32'h0, 32'h0, "wrap_wr");
    apply_stimulus(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0, "wrap_rd");
    check_output("wrap_word", dout_b, 32'h5A5A_5A5A);
    apply_stimulus(0, 4'hF, 32'h0, 32'h1234_5678, 0, 4'h0, 32'h0, 32'h0, "gate_off");
    apply_stimulus(1, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, "gate_rd");
    check_output("gate_word", dout_a, 32'h5A5A_5A5A);

    // Reset asserted mid-access aborts the write and clears outputs at once.
    en_a = 1; we_a = 4'hF; addr_a = 32'h20; din_a = 32'hCAFE_F00D;
    en_b = 1; we_b = 4'h0; addr_b = 32'h0;
    #2 reset = 0;
    exp_a = 0;
    exp_b = 0;
    #1;
    check_output("abort_clr_a", dout_a, 32'h0);
    check_output("abort_clr_b", dout_b, 32'h0);
    @(posedge clk);
    #1;
    check_output("abort_hold_a", dout_a, 32'h0);
    @(negedge clk);
    reset = 1;
    apply_stimulus(1, 4'h0, 32'h20, 32'h0, 0, 4'h0, 32'h0, 32'h0, "abort_rd");

    // Streaming: B fetches alternately the word A writes this edge and the
    // one A wrote the previous edge.
    for (int k = 0; k < 100; k++) begin
      apply_stimulus(1, 4'hF, 32'(256 + k) << 2, $urandom(),
                     1, 4'h0, 32'(256 + k - (k % 2)) << 2, 32'h0, "stream");
    end

    // Randomised traffic over a small window, with aliased upper bits.
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), 4'($urandom()),
                     rand_addr($urandom_range(0, 31)), $urandom(),
                     1'($urandom_range(0, 3) != 0), 4'($urandom()),
                     rand_addr($urandom_range(0, 31)), $urandom(), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/new_unified_memory.md
# new_unified_memory

True dual-port, byte-writable, synchronous-read RAM that serves as the single unified instruction/data store of the Hubris RV32 system. Port A carries general load/store traffic; port B carries instruction fetch. Both ports share one clock, take byte addresses and transfer 32-bit little-endian words. Contents are preloadable through the array `mem` for simulation.

## Interface
- MEMORY_WIDTH_IN_BYTE, 4: bytes per word. Only 4 is supported, giving a 32-bit data path.
- MEMORY_DEPTH_IN_WORD, 1048576: number of words (4 MiB). Must be a power of two, ≥ 2.
- clk  in  1  single clock for both ports.
- reset  in  1  asynchronous, active-low; clears both output registers.
- en_a  in  1  port A enable; without it, no read or write happens on port A.
- we_a  in  4  port A byte write enables; bit i writes byte lane i.
- addr_a  in  32  port A byte address.
- din_a  in  32  port A write data.
- dout_a  out  32  port A registered read data.
- en_b, we_b, addr_b, din_b, dout_b: identical meaning for port B.

## Operation
- Storage is `reg [31:0] mem [0:MEMORY_DEPTH_IN_WORD-1]`.
  - The name `mem` and parameter `MEMORY_DEPTH_IN_WORD` must stay hierarchically visible, for `$readmemh` and memory dumps.
- Word index = addr[AW+1:2], where AW = log2(MEMORY_DEPTH_IN_WORD).
  - addr[1:0] is ignored; the access is always word-aligned.
  - Address bits above AW+1 are ignored, so addresses wrap modulo the memory size.
- Byte lanes: we[0] selects bits 7:0, we[1] selects 15:8, we[2] selects 23:16, we[3] selects 31:24.
- Write: when en and we[i] are high at a rising clock edge, byte lane i of the addressed word takes din lane i. Unselected lanes keep their value.
- Read: when en is high, dout is loaded with the addressed word at the clock edge. This happens whether or not any we bit is set.
- Same-port read during write is read-first: dout shows the word as it was before that edge's write.
- When en is low, dout holds its last value and memory is unchanged.
- Cross-port collision (same word, same edge):
  - Lanes written by both ports take port A's data. Lanes written by only one port take that port's data.
  - A read on either port returns the pre-edge value.
- Reset low forces dout_a and dout_b to 0 immediately.
  - Memory contents are NOT cleared by reset.
  - Writes and reads are suppressed while reset is low.
- Memory contents power up undefined (X) unless preloaded.

## Timing
- Read latency is 1 cycle. Address presented with en at edge N gives data valid on dout after edge N and stable through edge N+1.
- Write latency is 1 cycle. A word written at edge N is readable by either port with a read issued at edge N+1.
- Back-to-back accesses on every cycle are supported on both ports simultaneously.
- Reset is asserted asynchronously and released synchronously to clk.
  - Reset asserted mid-access aborts that edge's write.
  - dout stays 0 until the first enabled read after release.
- There is no handshake or stall: the memory is always ready.

## Structure
- Shared package `hubris_pkg` holds:
  - XLEN = 32
  - BYTES_PER_WORD = 4
  - the default depth
  - a `word_index` helper (byte address to word index).
- The single natural sub-module is `ram_port`. It is instantiated twice and each instance contains:
  - the enable/byte-write logic
  - the read-first output register with async clear.
- The `mem` array lives in the top. Port A's write block is ordered after port B's, so A wins collisions.

## Test plan
- Reset and output clear:
  - Preload mem[0]=0x00000013, then hold reset low.
  - Required: dout_a=dout_b=0 asynchronously.
  - After release, an en_b read at addr 0x0 gives dout_b=0x00000013 one cycle later.
- Byte-lane write:
  - mem[1]=0xAABBCCDD; port A writes addr 0x4, we_a=0101, din_a=0x11223344.
  - Next read of 0x4 gives 0xAA22CC44.
  - Addresses 0x5, 0x6 and 0x7 read the same word.
- Read-first:
  - Port A writes 0xDEADBEEF to addr 0x8 (old value 0x0) with we_a=1111.
  - dout_a after that edge is 0x0. A read the following cycle gives 0xDEADBEEF.
- Collision:
  - Same edge: A writes 0x01020304 (we_a=0011) and B writes 0xA0B0C0D0 (we_b=0110), both to 0x10, old value 0xFFFFFFFF.
  - Result is 0xFFB00304.
- Wrap and enable gating:
  - Write 0x5A5A5A5A to addr 0x400000 (depth 1M), then read addr 0x0 on port B; it returns 0x5A5A5A5A.
  - With en_a=0, dout_a holds its prior value and we_a has no effect.
- Concurrent streaming:
  - Port B fetches 100 sequential words while port A stores to the same range one cycle ahead.
  - Each port B read returns the port A value when issued at least 1 cycle after the write edge, and the old value when issued on the same edge.
